// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input reordering block: default sizing
// and the frame-alignment state machine encoding.
package fft_pkg;

    // log2 of the FFT length N (legal range 3..12)
    localparam int DEFAULT_LGSIZE = 5;

    // Bits per real/imaginary component; one sample is 2*WIDTH bits
    localparam int DEFAULT_WIDTH = 24;

    // Frame alignment states:
    //   IDLE - waiting for the first i_sync, nothing is written
    //   FILL - the first frame after a (re)alignment is being written,
    //          so there is no complete frame to read yet
    //   RUN  - steady state, one frame written while the previous is read
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage : fft_pkg

// File: rtl/bitrev_bank.sv
// One N-entry sample bank: a single write port and two independent
// registered read ports. The top level uses one bank for even-index
// samples and one for odd-index samples. Contents are never reset; the
// top level guarantees nothing unwritten is ever forwarded.
module bitrev_bank
    import fft_pkg::*;
#(
    parameter int LGSIZE = DEFAULT_LGSIZE,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [LGSIZE-1:0]    wr_addr,
    input  logic [2*WIDTH-1:0]   wr_data,
    input  logic [LGSIZE-1:0]    rd_addr_a,
    input  logic [LGSIZE-1:0]    rd_addr_b,
    output logic [2*WIDTH-1:0]   rd_data_a,
    output logic [2*WIDTH-1:0]   rd_data_b
);

    localparam int DEPTH = 1 << LGSIZE;

    // Storage is addressed {page, index}: the page bit selects the half
    // being written versus the half being read.
    logic [2*WIDTH-1:0] mem [DEPTH];

    // Write port: one sample per enabled cycle
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port A: registered, holds while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
        end
    end

    // Read port B: registered, holds while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_b <= mem[rd_addr_b];
        end
    end

endmodule : bitrev_bank

// File: rtl/input_bitreverse.sv
// Reorders frames of N complex samples, arriving two per cycle in natural
// order, into bit-reversed order for a decimation-in-time FFT.
//
// Sample x[m] is stored in bank m[0] (E for even m, O for odd m) at
// address {page, m>>1}. Input pair k writes E[{page,k}] and O[{page,k}].
// While one page is written the other page holds the previous frame and
// is read out: output pair j needs x[r] and x[r+N/2] with r = rev(j) over
// LGSIZE-1 bits. Both samples share the parity r[0], so one bank supplies
// both through its two read ports, at addresses r>>1 and (r>>1)+N/4.
//
// Pipeline: read addresses are issued from k on the cycle a pair is
// written, the banks register the data, then the bank-select mux is
// registered into o_out_0/o_out_1. Pair 0 written on enabled cycle t
// gives output pair 0 (and o_sync) on enabled cycle t+N/2+1.
//
// Stream handshake: there is no backpressure. i_clk_enable qualifies
// every cycle; when it is low every register (state, counter, page,
// read pipeline, outputs) holds and no memory write happens. i_sync is
// meaningful only on enabled cycles and marks input pair 0.
module input_bitreverse
    import fft_pkg::*;
#(
    parameter int LGSIZE = DEFAULT_LGSIZE,
    parameter int WIDTH  = DEFAULT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clk_enable,
    input  logic                 i_sync,
    input  logic [2*WIDTH-1:0]   i_in_0,
    input  logic [2*WIDTH-1:0]   i_in_1,
    output logic [2*WIDTH-1:0]   o_out_0,
    output logic [2*WIDTH-1:0]   o_out_1,
    output logic                 o_sync
);

    localparam int N   = 1 << LGSIZE;
    localparam int QTR = N / 4;
    localparam int KW  = LGSIZE - 1;          // width of the pair counter
    localparam int SW  = 2 * WIDTH;           // width of one sample

    localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
    localparam logic [KW-1:0] K_ZERO = '0;
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] QTR_K  = KW'(QTR);

    // Frame alignment state
    state_t state;
    state_t next_state;

    // Write-side pair counter and ping-pong page
    logic [KW-1:0] k;
    logic          page;

    // FSM outputs
    logic          wr_en;      // write the current pair this cycle
    logic          realign;    // i_sync seen mid-frame: restart the frame
    logic          rd_go;      // launch a bank read that will be emitted

    // Address generation
    logic [KW-1:0]     rev_k;
    logic [KW-1:0]     rd_lo;
    logic [KW-1:0]     rd_hi;
    logic [LGSIZE-1:0] wr_addr;
    logic [LGSIZE-1:0] rd_addr_a;
    logic [LGSIZE-1:0] rd_addr_b;

    // Bank read data
    logic [SW-1:0] even_a;
    logic [SW-1:0] even_b;
    logic [SW-1:0] odd_a;
    logic [SW-1:0] odd_b;

    // Read pipeline qualifiers, aligned with the bank read registers
    logic rd_valid;
    logic rd_first;
    logic rd_sel;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register: advances only on enabled cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else if (i_clk_enable) begin
            state <= next_state;
        end
    end

    // Next-state logic: a mid-frame i_sync always returns to FILL, and a
    // frame mark at k==0 in RUN is consistent and changes nothing
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (i_sync) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (i_sync && (k != K_ZERO)) begin
                    next_state = FILL;
                end else if (k == K_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (i_sync && (k != K_ZERO)) begin
                    next_state = FILL;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // FSM outputs: write strobe, realignment and read launch
    always_comb begin
        wr_en   = 1'b0;
        realign = 1'b0;
        rd_go   = 1'b0;
        case (state)
            IDLE: begin
                wr_en = i_clk_enable && i_sync;
            end
            FILL: begin
                wr_en   = i_clk_enable;
                realign = i_clk_enable && i_sync && (k != K_ZERO);
            end
            RUN: begin
                wr_en   = i_clk_enable;
                realign = i_clk_enable && i_sync && (k != K_ZERO);
                rd_go   = !realign;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pair counter and page
    // ------------------------------------------------------------------

    // Counter/page update: a realignment writes the current pair as pair 0
    // of the opposite page, so the next pair is 1 on that page
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            k    <= K_ZERO;
            page <= 1'b0;
        end else if (wr_en) begin
            if (realign) begin
                k    <= K_ONE;
                page <= ~page;
            end else if (k == K_LAST) begin
                k    <= K_ZERO;
                page <= ~page;
            end else begin
                k <= k + K_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------

    // Bit reversal of the pair counter over LGSIZE-1 bits
    always_comb begin
        rev_k = '0;
        for (int i = 0; i < KW; i++) begin
            rev_k[i] = k[KW-1-i];
        end
    end

    // Read and write addresses: writes go to the current page (or the
    // opposite page's slot 0 on a realignment), reads come from the
    // other page, which holds the last complete frame
    always_comb begin
        rd_lo     = {1'b0, rev_k[KW-1:1]};
        rd_hi     = rd_lo + QTR_K;
        rd_addr_a = {~page, rd_lo};
        rd_addr_b = {~page, rd_hi};
        if (realign) begin
            wr_addr = {~page, K_ZERO};
        end else begin
            wr_addr = {page, k};
        end
    end

    // ------------------------------------------------------------------
    // Sample banks
    // ------------------------------------------------------------------

    bitrev_bank #(
        .LGSIZE (LGSIZE),
        .WIDTH  (WIDTH)
    ) u_bank_even (
        .clk       (i_clk),
        .rd_en     (i_clk_enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (i_in_0),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (even_a),
        .rd_data_b (even_b)
    );

    bitrev_bank #(
        .LGSIZE (LGSIZE),
        .WIDTH  (WIDTH)
    ) u_bank_odd (
        .clk       (i_clk),
        .rd_en     (i_clk_enable),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (i_in_1),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (odd_a),
        .rd_data_b (odd_b)
    );

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------

    // Read qualifiers travel alongside the bank read registers: whether the
    // read is live, whether it is output pair 0, and which bank it uses
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            rd_sel   <= 1'b0;
        end else if (i_clk_enable) begin
            rd_valid <= rd_go;
            rd_first <= (k == K_ZERO);
            rd_sel   <= rev_k[0];
        end
    end

    // Output register: bank-select mux, forced to zero when no live read
    // is in the pipeline so stale memory contents never escape
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_out_0 <= '0;
            o_out_1 <= '0;
            o_sync  <= 1'b0;
        end else if (i_clk_enable) begin
            o_sync <= rd_valid && rd_first;
            if (!rd_valid) begin
                o_out_0 <= '0;
                o_out_1 <= '0;
            end else if (rd_sel) begin
                o_out_0 <= odd_a;
                o_out_1 <= odd_b;
            end else begin
                o_out_0 <= even_a;
                o_out_1 <= even_b;
            end
        end
    end

endmodule : input_bitreverse

// File: doc/input_bitreverse.md
INPUT_BITREVERSE -- requirements
Module: input_bitreverse

Interface
REQ-001 Parameter LGSIZE, default 5: log2 of FFT length N; legal range 3..12.
REQ-002 Parameter WIDTH, default 24: bits per real/imag component, so each sample is 2*WIDTH bits.
REQ-003 i_clk  input  1  sole clock; all state is updated on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_clk_enable  input  1  advance enable; when low, all state holds.
REQ-006 i_sync  input  1  marks the first pair (pair 0) of an input frame; sampled only while i_clk_enable is high.
REQ-007 i_in_0  input  2*WIDTH  natural-order sample x[2k] of input pair k.
REQ-008 i_in_1  input  2*WIDTH  natural-order sample x[2k+1] of input pair k.
REQ-009 o_out_0  output  2*WIDTH  bit-reversed-order sample x[rev(2j)] of output pair j.
REQ-010 o_out_1  output  2*WIDTH  bit-reversed-order sample x[rev(2j+1)] of output pair j.
REQ-011 o_sync  output  1  high for exactly one enabled cycle, coincident with output pair 0 of a frame.

Function
REQ-012 The block reorders each N-sample frame, arriving as N/2 pairs per frame, from natural order into LGSIZE-bit bit-reversed order, for the input of a DIT FFT.
REQ-013 Output pair j: o_out_0 = x[r], o_out_1 = x[r+N/2], where r = (LGSIZE-1)-bit reversal of j, j = 0..N/2-1.
REQ-014 Storage: two banks (E = even-index samples, O = odd-index samples), each N entries deep, organised ping-pong as {page, k}; x[m] resides in bank m[0] at address m>>1.
REQ-015 Read for pair j: the bank is selected by r[0] (= j[LGSIZE-2]); addresses are {!page, r>>1} and {!page, (r>>1)+N/4}; the selected data is registered directly into o_out_0/o_out_1.
REQ-016 Write: on each enabled cycle in FILL or RUN, E[{page,k}] <= i_in_0 and O[{page,k}] <= i_in_1; k then increments, and page toggles when k wraps from N/2-1 to 0.
REQ-017 FSM states and transitions:
  - IDLE -> FILL on i_sync; that cycle writes pair 0.
  - FILL -> RUN after pair N/2-1 is written.
  - RUN continues indefinitely.
REQ-018 Latency: with pair 0 written on enabled cycle t, o_sync and output pair 0 are visible on enabled cycle t+N/2+1; output pairs follow contiguously, one per enabled cycle.
REQ-019 In IDLE and FILL, o_out_0, o_out_1 and o_sync are 0.
REQ-020 i_sync in RUN with k==0 is a consistent frame mark and causes no change.
REQ-021 i_sync in RUN or FILL with k!=0 realigns the block:
  - k restarts at 0 on the opposite page, with the current pair written as pair 0.
  - State goes to FILL.
  - Outputs go to 0 from the next enabled cycle until the new frame emerges per REQ-018.
REQ-022 i_sync is not required on later frames; the wrap of k defines frame boundaries.
REQ-023 i_clk_enable low freezes k, page, state and the output registers, and performs no memory write.

Reset
REQ-024 Asserting i_reset immediately forces: state=IDLE, k=0, page=0, o_sync=0, o_out_0=0, o_out_1=0.
REQ-025 Memory contents are not reset; after reset, no stale data reaches the outputs, because outputs stay 0 until RUN.
REQ-026 Reset asserted mid-frame discards the partial frame; operation restarts only at the next i_sync.

Structure
REQ-027 Package fft_pkg holds the LGSIZE and WIDTH defaults and the FSM state enum (IDLE, FILL, RUN).
REQ-028 One sub-module, bitrev_bank, SHALL implement a single N-entry bank with one write port and two registered read ports; it is instantiated twice (E and O).
REQ-029 The top level contains the FSM, the counter/page logic, address bit-reversal, and the bank-select output mux/register.

Verification (LGSIZE=5, N=32, sample x[m]=m)
REQ-030 Continuous enable; i_sync with pair 0 at cycle 0 -> o_sync at cycle 17; pairs read (0,16),(8,24),(4,20),(12,28) ... (15,31).
REQ-031 Three back-to-back frames with i_sync only on the first -> gapless output; o_sync at cycles 17, 33, 49; each frame is correct.
REQ-032 Random i_clk_enable deassertions (about 30%) -> the output sequence is identical to REQ-030 when counted in enabled cycles, and outputs hold while enable is low.
REQ-033 i_sync reasserted at pair 5 of the second frame -> outputs become 0 one enabled cycle later; o_sync returns 17 enabled cycles after the new pair 0, with correct data.
REQ-034 i_reset pulsed mid-RUN (asynchronous, between edges) -> outputs and o_sync are 0 immediately; no output until i_sync plus 17 enabled cycles.
REQ-035 No i_sync after reset, with 100 enabled cycles of input -> o_sync and outputs remain 0.
